ram_dump: RTL and testbench
===========================

RAM_DUMP -- requirements
Module: ram_dump

Interface
REQ-001 ADDR_W, default 8, RAM address width (256 words).
REQ-002 DATA_W, default 16, RAM word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a dump; honoured only in IDLE.
REQ-006 base_addr  input  ADDR_W  first address to dump; sampled when start is accepted.
REQ-007 last_addr  input  ADDR_W  final address to dump, inclusive; sampled when start is accepted.
REQ-008 busy  output  1  high from start acceptance until the done pulse, inclusive.
REQ-009 done  output  1  one-cycle pulse after the last word is accepted downstream.
REQ-010 mem_rd_en  output  1  RAM read strobe.
REQ-011 mem_addr  output  ADDR_W  RAM read address.
REQ-012 mem_rd_data  input  DATA_W  RAM read data, valid exactly one cycle after mem_rd_en.
REQ-013 out_valid  output  1  output word available.
REQ-014 out_ready  input  1  downstream accepts the word when out_valid and out_ready are both high.
REQ-015 out_data  output  DATA_W  dumped word.
REQ-016 out_addr  output  ADDR_W  address of out_data.
REQ-017 out_last  output  1  high with the word at last_addr.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, READ, WAIT, SEND and DONE.
REQ-019 IDLE: start=1 SHALL latch base_addr into a pointer and last_addr into an end register, then move to READ; start=0 holds IDLE.
REQ-020 READ: mem_rd_en=1 and mem_addr=pointer for exactly one cycle; next state WAIT.
REQ-021 WAIT: mem_rd_data SHALL be registered into out_data, with out_addr=pointer and out_last=(pointer==end); next state SEND.
REQ-022 SEND: out_valid=1, and out_data, out_addr and out_last SHALL remain stable until the handshake completes.
REQ-023 On a SEND handshake with out_last=1 the FSM SHALL go to DONE; otherwise the pointer SHALL increment modulo 2^ADDR_W and the FSM SHALL go to READ.
REQ-024 DONE: done=1 for one cycle; next state IDLE.
REQ-025 Wrap-around: if last_addr < base_addr, the dump SHALL run base_addr..255, then 0..last_addr.
REQ-026 If base_addr == last_addr, exactly one word SHALL be dumped, with out_last=1.
REQ-027 Latency: start acceptance to first out_valid SHALL be 3 cycles; the interval between accepted words SHALL be at least 3 cycles.
REQ-028 start while busy SHALL be ignored, with no effect on the pointer, end register or state.
REQ-029 out_valid SHALL be low in every state other than SEND; mem_rd_en SHALL be low in every state other than READ.
REQ-030 Backpressure: out_ready=0 in SEND SHALL hold SEND indefinitely, with no further RAM reads.
REQ-031 busy SHALL be high in READ, WAIT, SEND and DONE, and low in IDLE.

Reset
REQ-032 rst=1 SHALL immediately force IDLE, with busy, done, mem_rd_en, out_valid and out_last at 0, and mem_addr, out_addr, out_data, the pointer and the end register at 0.
REQ-033 rst asserted mid-dump SHALL abort the dump with no done pulse; the first start after rst deasserts SHALL begin a fresh dump.

Structure
REQ-034 ADDR_W, DATA_W defaults and the FSM state encodings SHALL live in the shared SAP package, alongside the CPU constants.
REQ-035 The block SHALL be a single module with no sub-modules; it connects to a read port of the existing RAM.

Verification
REQ-036 Preload mem[0]=0000, mem[1]=0001; start with base=0, last=1, out_ready=1 -> words (0,0000) then (1,0001) with out_last on the second; one done pulse; first out_valid 3 cycles after start.
REQ-037 Preload mem[10..18]=0000,0B00,0201,0102,0001,0100,0002,0101,080A; dump base=10, last=18 -> 9 words in order, out_last only at addr 18.
REQ-038 base=254, last=1 with mem[254]=AAAA, mem[255]=BBBB, mem[0]=0000, mem[1]=0001 -> addresses 254, 255, 0, 1 in that order, with those data values.
REQ-039 base=last=11 -> one word 0B00 with out_last=1, then done; hold out_ready=0 for 10 cycles in SEND -> data stable and no mem_rd_en pulses.
REQ-040 Assert rst during SEND of a 9-word dump -> all outputs 0 and no done pulse; then start with base=0, last=0 -> single word 0000.
REQ-041 Pulse start again during an active dump -> ignored, and the original sequence completes unchanged.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared SAP package: CPU constants plus the parameters and state encoding
// used by the RAM dump port.
package sap_pkg;

    localparam int SAP_ADDR_W    = 8;
    localparam int SAP_DATA_W    = 16;
    localparam int SAP_RAM_DEPTH = 1 << SAP_ADDR_W;

    // CPU instruction opcodes occupy the upper byte of a RAM word.
    typedef enum logic [7:0] {
        OP_NOP = 8'h00,
        OP_LDA = 8'h01,
        OP_ADD = 8'h02,
        OP_SUB = 8'h03,
        OP_OUT = 8'h0E,
        OP_HLT = 8'h0F
    } sap_opcode_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } dump_state_t;

endpackage

// File: rtl/ram_dump.sv
// Walks a RAM read port from base_addr to last_addr (inclusive, wrapping)
// and streams each word downstream over a valid/ready handshake.
module ram_dump
    import sap_pkg::*;
#(
    parameter int ADDR_W = SAP_ADDR_W,
    parameter int DATA_W = SAP_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last
);

    dump_state_t       r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_end;
    logic              r_busy;
    logic              r_done;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_out_last;

    logic [ADDR_W-1:0] w_ptr_next;
    logic              w_handshake;

    // Natural overflow of the increment gives the modulo-2^ADDR_W wrap.
    assign w_ptr_next  = r_ptr + ADDR_W'(1);
    assign w_handshake = r_valid && out_ready;

    // NOTE: every register here uses <= so all updates see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_end      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_en    <= 1'b0;
            r_mem_addr <= '0;
            r_valid    <= 1'b0;
            r_out_data <= '0;
            r_out_addr <= '0;
            r_out_last <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ptr      <= base_addr;
                        r_end      <= last_addr;
                        r_mem_addr <= base_addr;
                        r_rd_en    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= READ;
                    end
                end
                READ: begin
                    r_rd_en <= 1'b0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_out_data <= mem_rd_data;
                    r_out_addr <= r_ptr;
                    r_out_last <= (r_ptr == r_end);
                    r_valid    <= 1'b1;
                    r_state    <= SEND;
                end
                SEND: begin
                    // Output word is held untouched while downstream stalls.
                    if (w_handshake) begin
                        r_valid <= 1'b0;
                        if (r_out_last) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_ptr      <= w_ptr_next;
                            r_mem_addr <= w_ptr_next;
                            r_rd_en    <= 1'b1;
                            r_state    <= READ;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign mem_rd_en = r_rd_en;
    assign mem_addr  = r_mem_addr;
    assign out_valid = r_valid;
    assign out_data  = r_out_data;
    assign out_addr  = r_out_addr;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_ram_dump.sv
// Scoreboard bench for ram_dump: stimulus queues expected words, a monitor
// pops and compares them on every downstream handshake.
module tb_ram_dump;

    localparam int AW = 8;
    localparam int DW = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] last_addr;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;

    logic [DW-1:0] mem [256];
    word_t         exp_q[$];

    int n_checks   = 0;
    int n_pass     = 0;
    int done_count = 0;
    int rd_count   = 0;

    ram_dump #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .last_addr   (last_addr),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_addr    (out_addr),
        .out_last    (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM: data appears one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_count++;
            if (mem_rd_en) rd_count++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got addr=%0h data=%0h last=%0b, none expected",
                             out_addr, out_data, out_last);
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    check($sformatf("word@%0h {addr,data,last}", e.addr),
                          64'({out_addr, out_data, out_last}), 64'(e));
                end
            end
        end
    end

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
        word_t w;
        w.addr = a;
        w.data = d;
        w.last = l;
        exp_q.push_back(w);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] l);
        int n;
        base_addr = b;
        last_addr = l;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_accept", 64'(busy), 64'd1);
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("start_to_first_valid", 64'(n), 64'd3);
    endtask

    task automatic wait_idle(input int exp_dones);
        int n;
        n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        check("dump_completes_in_budget", 64'(n < 400), 64'd1);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("done_pulse_count", 64'(done_count), 64'(exp_dones));
        check("done_low_in_idle", 64'(done), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_done"},      64'(done),      64'd0);
        check({tag, "_mem_rd_en"}, 64'(mem_rd_en), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_last"},  64'(out_last),  64'd0);
        check({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
        check({tag, "_out_addr"},  64'(out_addr),  64'd0);
        check({tag, "_out_data"},  64'(out_data),  64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] prog [9];
        logic [DW-1:0] held_data;
        logic [AW-1:0] held_addr;
        logic          held_last;
        int            rd_before;
        int            dones_before;

        rst       = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        last_addr = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 16'hDEAD;
        #1 rst = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Two-word dump from address 0.
        mem[0] = 16'h0000;
        mem[1] = 16'h0001;
        push(8'd0, 16'h0000, 1'b0);
        push(8'd1, 16'h0001, 1'b1);
        do_start(8'd0, 8'd1);
        wait_idle(1);

        // Nine-word program dump; a second start mid-dump must be ignored.
        prog = '{16'h0000, 16'h0B00, 16'h0201, 16'h0102, 16'h0001,
                 16'h0100, 16'h0002, 16'h0101, 16'h080A};
        for (int i = 0; i < 9; i++) begin
            mem[10 + i] = prog[i];
            push(AW'(10 + i), prog[i], (i == 8));
        end
        do_start(8'd10, 8'd18);
        repeat (5) tick();
        base_addr = 8'd0;
        last_addr = 8'd0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(2);

        // Wrap-around from 254 through 1.
        mem[254] = 16'hAAAA;
        mem[255] = 16'hBBBB;
        push(8'd254, 16'hAAAA, 1'b0);
        push(8'd255, 16'hBBBB, 1'b0);
        push(8'd0,   16'h0000, 1'b0);
        push(8'd1,   16'h0001, 1'b1);
        do_start(8'd254, 8'd1);
        wait_idle(3);

        // Single word with downstream stalled for 10 cycles.
        out_ready = 1'b0;
        push(8'd11, 16'h0B00, 1'b1);
        do_start(8'd11, 8'd11);
        held_data = out_data;
        held_addr = out_addr;
        held_last = out_last;
        rd_before = rd_count;
        repeat (10) tick();
        check("stall_valid_held", 64'(out_valid), 64'd1);
        check("stall_data_stable", 64'(out_data), 64'(held_data));
        check("stall_data_value", 64'(out_data), 64'h0B00);
        check("stall_addr_stable", 64'(out_addr), 64'(held_addr));
        check("stall_last_stable", 64'(out_last), 64'(held_last));
        check("stall_no_reads", 64'(rd_count - rd_before), 64'd0);
        out_ready = 1'b1;
        wait_idle(4);

        // Reset in SEND of a nine-word dump aborts it without a done pulse.
        out_ready = 1'b0;
        do_start(8'd10, 8'd18);
        dones_before = done_count;
        tick();
        #2 rst = 1'b1;
        #1 check_reset_outputs("abort");
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("abort_no_done", 64'(done_count), 64'(dones_before));
        check("abort_idle", 64'(busy), 64'd0);
        out_ready = 1'b1;
        push(8'd0, 16'h0000, 1'b1);
        do_start(8'd0, 8'd0);
        wait_idle(dones_before + 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
